// File: rtl/spi_egress_frame_packer.sv
`timescale 1ns/1ps
// Packs wide readout words into length-prefixed byte frames for the SPI MISO egress FIFO.
// A header byte {HEADER_ID, len} precedes up to MTU_SIZE payload bytes; partial frames flush after idle time.
module spi_egress_frame_packer #(
   parameter int unsigned WORD_BYTES    = 4,
   parameter int unsigned MTU_SIZE      = 16,
   parameter bit          MSB_FIRST     = 1'b1,
   parameter logic [2:0]  HEADER_ID     = 3'b101,
   parameter logic [7:0]  IDLE_BYTE     = 8'h3C,
   parameter int unsigned FLUSH_TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    resn,
   input  logic [WORD_BYTES*8-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [7:0]              m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic [7:0]              m_axis_tuser,
   output logic [15:0]             frame_count
);
   // state      | meaning
   // ST_FILL    | accepting words into the frame buffer
   // ST_HEADER  | presenting the length header byte
   // ST_PAYLOAD | presenting buffered payload bytes in order
   typedef enum logic [1:0] {ST_FILL, ST_HEADER, ST_PAYLOAD} state_t;

   localparam int unsigned  AW        = (MTU_SIZE > 1) ? $clog2(MTU_SIZE) : 1;
   localparam int unsigned  IW        = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
   localparam logic [4:0]   WB_LEN    = 5'(WORD_BYTES);
   localparam logic [4:0]   MTU_LEN   = 5'(MTU_SIZE);
   localparam logic [IW-1:0] IDLE_LAST = IW'(FLUSH_TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [4:0]      fill_q, fill_d;
   logic [4:0]      rd_q, rd_d;
   logic [IW-1:0]   idle_q, idle_d;
   logic [15:0]     frame_count_q, frame_count_d;
   logic            tready_q;
   logic            accept;
   logic            wr_en;
   logic [7:0]      byte_mem [MTU_SIZE];

   assign accept        = (state_q == ST_FILL) && s_axis_tvalid && tready_q;
   assign s_axis_tready = tready_q;
   assign m_axis_tuser  = IDLE_BYTE;
   assign frame_count   = frame_count_q;

   always_comb begin
      state_d       = state_q;
      fill_d        = fill_q;
      rd_d          = rd_q;
      idle_d        = idle_q;
      frame_count_d = frame_count_q;
      wr_en         = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (accept) begin
               wr_en  = 1'b1;
               fill_d = fill_q + WB_LEN;
               idle_d = '0;
               if (s_axis_tlast || (fill_d == MTU_LEN)) begin
                  state_d = ST_HEADER;
               end
            end else if (fill_q != 5'd0) begin
               // an accept in the timeout cycle takes priority (handled above)
               if ((FLUSH_TIMEOUT != 0) && (idle_q == IDLE_LAST)) begin
                  state_d = ST_HEADER;
                  idle_d  = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end else begin
               idle_d = '0;
            end
         end
         ST_HEADER: begin
            if (m_axis_tready) begin
               rd_d    = '0;
               state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (m_axis_tready) begin
               if ((rd_q + 5'd1) == fill_q) begin
                  fill_d        = '0;
                  rd_d          = '0;
                  frame_count_d = frame_count_q + 16'd1;
                  state_d       = ST_FILL;
               end else begin
                  rd_d = rd_q + 5'd1;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         state_q       <= ST_FILL;
         fill_q        <= '0;
         rd_q          <= '0;
         idle_q        <= '0;
         frame_count_q <= '0;
         tready_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         fill_q        <= fill_d;
         rd_q          <= rd_d;
         idle_q        <= idle_d;
         frame_count_q <= frame_count_d;
         tready_q      <= (state_d == ST_FILL);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (MSB_FIRST) begin
               byte_mem[AW'(fill_q + 5'(i))] <= s_axis_tdata[(WORD_BYTES-1-i)*8 +: 8];
            end else begin
               byte_mem[AW'(fill_q + 5'(i))] <= s_axis_tdata[i*8 +: 8];
            end
         end
      end
   end

   // outputs depend on registered state only, so m_axis_tready never reaches them combinationally
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = 8'h00;
      m_axis_tlast  = 1'b0;
      case (state_q)
         ST_HEADER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = {HEADER_ID, fill_q};
         end
         ST_PAYLOAD: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = byte_mem[rd_q[AW-1:0]];
            m_axis_tlast  = ((rd_q + 5'd1) == fill_q);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spi_egress_frame_packer.sv
`timescale 1ns/1ps
// Bench for spi_egress_frame_packer: directed and randomised frames compared against a byte-queue frame model.
module tb_spi_egress_frame_packer;
   typedef logic [8:0] ent_t;   // {tlast, byte}

   localparam logic [31:0] T3W [4] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};

   logic        clk = 1'b0;
   logic        resn;
   logic [31:0] s_tdata;
   logic        s_tvalid, s_tlast, s_tready;
   logic [7:0]  m_tdata, m_tuser;
   logic        m_tvalid, m_tlast, m_tready;
   logic [15:0] fcount;

   logic [31:0] l_tdata;
   logic        l_tvalid, l_tlast, l_tready;
   logic [7:0]  l_mtdata, l_tuser;
   logic        l_mtvalid, l_mtlast, l_mready;
   logic [15:0] l_fcount;

   int          total = 0;
   int          bad = 0;
   int          n_exp;
   ent_t        exp_q[$];
   ent_t        got_q[$];
   logic [7:0]  pend_q[$];
   logic [15:0] frames_model = 16'd0;
   logic [15:0] fsave;
   logic [31:0] words[$];
   logic        lasts[$];

   always #5 clk = ~clk;

   spi_egress_frame_packer #(
      .WORD_BYTES(4), .MTU_SIZE(16), .MSB_FIRST(1'b1), .HEADER_ID(3'b101),
      .IDLE_BYTE(8'h3C), .FLUSH_TIMEOUT(8)
   ) dut (
      .clk(clk), .resn(resn),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .m_axis_tuser(m_tuser), .frame_count(fcount)
   );

   spi_egress_frame_packer #(
      .WORD_BYTES(4), .MTU_SIZE(16), .MSB_FIRST(1'b0), .HEADER_ID(3'b101),
      .IDLE_BYTE(8'h3C), .FLUSH_TIMEOUT(0)
   ) dut_lsb (
      .clk(clk), .resn(resn),
      .s_axis_tdata(l_tdata), .s_axis_tvalid(l_tvalid), .s_axis_tlast(l_tlast), .s_axis_tready(l_tready),
      .m_axis_tdata(l_mtdata), .m_axis_tvalid(l_mtvalid), .m_axis_tlast(l_mtlast), .m_axis_tready(l_mready),
      .m_axis_tuser(l_tuser), .frame_count(l_fcount)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference model: a frame is a header {101, len} followed by the pending bytes
   task automatic model_close();
      int n;
      n = pend_q.size();
      if (n == 0) return;
      exp_q.push_back({1'b0, 3'b101, 5'(n)});
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), pend_q[i]});
      pend_q.delete();
      frames_model++;
   endtask

   task automatic model_word(input logic [31:0] w, input logic last, input bit msb);
      for (int i = 0; i < 4; i++) pend_q.push_back(8'(w >> (msb ? 8 * (3 - i) : 8 * i)));
      if (last || pend_q.size() == 16) model_close();
   endtask

   task automatic compare_got(input string tag);
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic send_word(input logic [31:0] w, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      s_tdata = w; s_tlast = last; s_tvalid = 1'b1;
      while (!s_tready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", s_tready, 1);
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic collect(input int n, input bit rnd);
      int         cyc;
      bit         stall;
      logic [7:0] pd;
      logic       pl;
      cyc = 0; stall = 0; pd = '0; pl = 1'b0;
      while (got_q.size() < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (stall) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_data", m_tdata, pd);
            check("hold_last", m_tlast, pl);
         end
         check("tuser", m_tuser, 8'h3C);
         m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_tvalid && m_tready) begin
            got_q.push_back({m_tlast, m_tdata});
            stall = 0;
         end else begin
            stall = m_tvalid;
            pd = m_tdata;
            pl = m_tlast;
         end
      end
      check("collect_cnt", got_q.size(), n);
      @(posedge clk); #1;
      m_tready = 1'b0;
   endtask

   task automatic l_send(input logic [31:0] w, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      l_tdata = w; l_tlast = last; l_tvalid = 1'b1;
      while (!l_tready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("lsb_send_ready", l_tready, 1);
      @(posedge clk); #1;
      l_tvalid = 1'b0; l_tlast = 1'b0;
   endtask

   task automatic l_collect(input int n);
      int cyc;
      cyc = 0;
      while (got_q.size() < n && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (l_mtvalid) got_q.push_back({l_mtlast, l_mtdata});
      end
      check("lsb_collect_cnt", got_q.size(), n);
      @(posedge clk); #1;
   endtask

   initial begin
      resn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
      l_tdata = '0; l_tvalid = 1'b0; l_tlast = 1'b0; l_mready = 1'b1;
      repeat (3) @(posedge clk); #1;
      check("rst_s_tready", s_tready, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_fcount", fcount, 0);
      check("rst_tuser", m_tuser, 8'h3C);
      @(negedge clk); resn = 1'b1;
      @(posedge clk); #1;
      check("tready_after_rst", s_tready, 1);

      // single tlast word, MSB first
      send_word(32'hAABBCCDD, 1'b1); model_word(32'hAABBCCDD, 1'b1, 1'b1);
      check("t1_hdr_valid", m_tvalid, 1);
      check("t1_hdr", m_tdata, exp_q[0][7:0]);
      check("t1_tready_low", s_tready, 0);
      collect(5, 1'b0); compare_got("t1");
      check("t1_fcount", fcount, frames_model);
      check("t1_tready_back", s_tready, 1);

      // LSB-first instance, timeout disabled
      fsave = frames_model;
      l_send(32'hAABBCCDD, 1'b1); model_word(32'hAABBCCDD, 1'b1, 1'b0);
      l_collect(5); compare_got("t2");
      check("t2_fcount", l_fcount, frames_model - fsave);
      check("t2_tuser", l_tuser, 8'h3C);
      l_send(32'h11223344, 1'b0); model_word(32'h11223344, 1'b0, 1'b0);
      repeat (80) @(posedge clk); #1;
      check("t2_no_flush", l_mtvalid, 0);
      l_send(32'h55667788, 1'b1); model_word(32'h55667788, 1'b1, 1'b0);
      l_collect(9); compare_got("t2b");
      frames_model = fsave;

      // four words fill the MTU without tlast
      for (int i = 0; i < 4; i++) begin
         send_word(T3W[i], 1'b0); model_word(T3W[i], 1'b0, 1'b1);
         check($sformatf("t3_tready_%0d", i), s_tready, (i < 3));
      end
      check("t3_hdr_valid", m_tvalid, 1);
      check("t3_hdr", m_tdata, exp_q[0][7:0]);
      collect(17, 1'b0); compare_got("t3");
      check("t3_tready_back", s_tready, 1);
      check("t3_fcount", fcount, frames_model);

      // idle flush after 8 cycles
      send_word(32'hCAFEF00D, 1'b0); model_word(32'hCAFEF00D, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         check($sformatf("t4_wait_%0d", k), m_tvalid, (k == 8));
      end
      model_close();
      check("t4_hdr", m_tdata, exp_q[0][7:0]);
      collect(5, 1'b0); compare_got("t4");
      // a word arriving in the timeout cycle is stored instead
      send_word(32'h12345678, 1'b0); model_word(32'h12345678, 1'b0, 1'b1);
      repeat (7) @(posedge clk);
      send_word(32'h9ABCDEF0, 1'b0); model_word(32'h9ABCDEF0, 1'b0, 1'b1);
      check("t4_accept_wins", m_tvalid, 0);
      check("t4_tready_still", s_tready, 1);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         check($sformatf("t4b_wait_%0d", k), m_tvalid, (k == 8));
      end
      model_close();
      check("t4b_hdr", m_tdata, exp_q[0][7:0]);
      collect(9, 1'b0); compare_got("t4b");
      check("t4_fcount", fcount, frames_model);

      // random backpressure on the 16-byte frame
      for (int i = 0; i < 4; i++) model_word(T3W[i], 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) send_word(T3W[i], 1'b0);
      collect(17, 1'b1); compare_got("t5");

      // random words, random tlast, random gaps, random backpressure
      for (int i = 0; i < 14; i++) begin
         words.push_back($urandom);
         lasts.push_back(($urandom_range(0, 3) == 0) || (i == 13));
         model_word(words[i], lasts[i], 1'b1);
      end
      n_exp = exp_q.size();
      fork
         begin
            for (int i = 0; i < 14; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               send_word(words[i], lasts[i]);
            end
         end
         collect(n_exp, 1'b1);
      join
      compare_got("t5r");
      check("t5r_fcount", fcount, frames_model);

      // reset in the middle of a payload
      send_word(32'hAABBCCDD, 1'b1);
      collect(3, 1'b0); got_q.delete();
      check("t6_pre_valid", m_tvalid, 1);
      #2 resn = 1'b0;
      #1;
      check("t6_s_tready", s_tready, 0);
      check("t6_m_tvalid", m_tvalid, 0);
      check("t6_m_tlast", m_tlast, 0);
      check("t6_m_tdata", m_tdata, 0);
      check("t6_fcount", fcount, 0);
      @(negedge clk); resn = 1'b1;
      frames_model = 16'd0; exp_q.delete(); pend_q.delete();
      send_word(32'hAABBCCDD, 1'b1); model_word(32'hAABBCCDD, 1'b1, 1'b1);
      collect(5, 1'b0); compare_got("t6");
      check("t6_fcount_after", fcount, frames_model);

      // frame counter wrap from FFFF
      @(negedge clk);
      force dut.frame_count_q = 16'hFFFF;
      #1 release dut.frame_count_q;
      #1 check("wrap_preload", fcount, 16'hFFFF);
      frames_model = 16'hFFFF;
      send_word(32'h0BADBEEF, 1'b1); model_word(32'h0BADBEEF, 1'b1, 1'b1);
      collect(5, 1'b0); compare_got("wrap");
      check("wrap_fcount", fcount, frames_model);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
